// File: rtl/sram_arb_pkg.sv
// Shared defaults and FSM state type for the two-requester analog-coded SRAM arbiter.
package sram_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int ANA_WIDTH_DEF  = 8;
  localparam int FULL_SCALE_DEF = 255;
  localparam int THRESH_DEF     = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way grant logic. Round-robin by default; SRAM_ARB_FIXED_PRIO_EN makes
// requester 0 win every conflict and removes the last_grant register.
module sram_arb_rr (
  input  logic       clk_a,
  input  logic       rst_a_n,
  input  logic [1:0] req_valid,
  input  logic       hs,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_grant_d = hs ? grant[1] : last_grant_q;
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbitrates two requesters onto an analog-coded SRAM, one transaction at a time.
// Build option SRAM_ARB_FIXED_PRIO_EN (see sram_arb_rr) selects fixed priority.
//
// state | meaning
// IDLE  | waiting for a request handshake
// CMD   | analog command on we_a/addr_a/din_a, SRAM samples at end of cycle
// WAIT  | SRAM read data on dout_a, decoded into rsp_rdata at end of cycle
// RSP   | rsp_valid to owner until its rsp_ready
module sram_arb_ctrl
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ANA_WIDTH  = ANA_WIDTH_DEF,
  parameter int FULL_SCALE = FULL_SCALE_DEF,
  parameter int THRESH     = THRESH_DEF
) (
  input  logic                                  clk_a,
  input  logic                                  rst_a_n,
  input  logic [1:0]                            req_valid,
  output logic [1:0]                            req_ready,
  input  logic [1:0]                            req_we,
  input  logic [1:0][ADDR_WIDTH-1:0]            req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]            req_wdata,
  output logic [1:0]                            rsp_valid,
  input  logic [1:0]                            rsp_ready,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  busy,
  output logic [ANA_WIDTH-1:0]                  we_a,
  output logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0]  addr_a,
  output logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  din_a,
  input  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  dout_a
);

  localparam logic [ANA_WIDTH-1:0] LVL_ONE = ANA_WIDTH'(FULL_SCALE);
  localparam logic [ANA_WIDTH-1:0] LVL_THR = ANA_WIDTH'(THRESH);

  state_e                                state_q, state_d;
  logic                                  owner_q, owner_d;
  logic                                  rdy_en_q, rdy_en_d;
  logic [1:0]                            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]                 rdata_q, rdata_d;
  logic [ANA_WIDTH-1:0]                  we_a_q, we_a_d;
  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0]  addr_a_q, addr_a_d;
  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0]  din_a_q, din_a_d;
  logic [1:0]                            grant;
  logic                                  hs;
  logic                                  sel;

  sram_arb_rr u_rr (
    .clk_a     (clk_a),
    .rst_a_n   (rst_a_n),
    .req_valid (req_valid),
    .hs        (hs),
    .grant     (grant)
  );

  // rdy_en_q is a registered "in IDLE" flag that stays low through reset.
  assign req_ready = rdy_en_q ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel       = grant[1];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    we_a_d      = we_a_q;
    addr_a_d    = addr_a_q;
    din_a_d     = din_a_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d = ST_CMD;
          owner_d = sel;
          we_a_d  = req_we[sel] ? LVL_ONE : '0;
          for (int i = 0; i < ADDR_WIDTH; i++)
            addr_a_d[i] = req_addr[sel][i] ? LVL_ONE : '0;
          for (int i = 0; i < DATA_WIDTH; i++)
            din_a_d[i] = req_wdata[sel][i] ? LVL_ONE : '0;
        end
      end
      ST_CMD: begin
        state_d = ST_WAIT;
        we_a_d  = '0;
      end
      ST_WAIT: begin
        state_d              = ST_RSP;
        rsp_valid_d[owner_q] = 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++)
          rdata_d[i] = (dout_a[i] >= LVL_THR);
      end
      ST_RSP: begin
        if (rsp_ready[owner_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_en_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rdy_en_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rdata_q     <= '0;
      we_a_q      <= '0;
      addr_a_q    <= '0;
      din_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rdy_en_q    <= rdy_en_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      we_a_q      <= we_a_d;
      addr_a_q    <= addr_a_d;
      din_a_q     <= din_a_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign we_a      = we_a_q;
  assign addr_a    = addr_a_q;
  assign din_a     = din_a_q;

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
- REQ-001 SHALL have parameters: DATA_WIDTH, default 8, data bits per word; ADDR_WIDTH, default 4, address bits; ANA_WIDTH, default 8, bits per analog-coded level; FULL_SCALE, default 255, level for logic 1; THRESH, default 128, decode threshold.
- REQ-002 SHALL have ports:
  - clk_a, input, 1, digital clock driving the SRAM, rising edge.
  - rst_a_n, input, 1, asynchronous active-low reset.
  - req_valid, input, [1:0], request valid per requester.
  - req_ready, output, [1:0], request accepted per requester.
  - req_we, input, [1:0], 1 means write.
  - req_addr, input, [2][ADDR_WIDTH], address per requester.
  - req_wdata, input, [2][DATA_WIDTH], write data per requester.
  - rsp_valid, output, [1:0], response valid, one-hot owner.
  - rsp_ready, input, [1:0], response accepted.
  - rsp_rdata, output, DATA_WIDTH, decoded SRAM data.
  - busy, output, 1, high when FSM is not IDLE.
  - we_a, output, ANA_WIDTH, analog-coded write enable to SRAM.
  - addr_a, output, [ADDR_WIDTH][ANA_WIDTH], analog-coded address.
  - din_a, output, [ADDR_WIDTH→DATA_WIDTH][ANA_WIDTH], analog-coded write data.
  - dout_a, input, [DATA_WIDTH][ANA_WIDTH], analog-coded SRAM read data.
- REQ-003 SHALL use one clock; reset SHALL be asynchronous, active-low.

Function
- REQ-004 SHALL implement FSM IDLE -> CMD -> WAIT -> RSP -> IDLE; one transaction in flight; minimum 4 cycles per transaction.
- REQ-005 In IDLE, SHALL assert req_ready only for the granted requester with req_valid=1; handshake = valid&&ready; on handshake latch we/addr/wdata and owner, go CMD.
- REQ-006 Arbitration: round-robin; last_grant resets to 1; on a conflict, the requester != last_grant wins; last_grant updates on each handshake.
- REQ-007 In CMD, registered outputs SHALL encode each bit as FULL_SCALE (1) or 0 (0): we_a from latched we, addr_a[i], din_a[i]; SRAM samples at end of CMD.
- REQ-008 Outside CMD, we_a SHALL be 0; addr_a and din_a SHALL hold their last values.
- REQ-009 In WAIT, SHALL capture rsp_rdata[i] = (dout_a[i] >= THRESH) at end of cycle, for reads and writes alike (read-first: a write returns old data).
- REQ-010 In RSP, rsp_valid[owner]=1, rsp_rdata stable; SHALL stay until rsp_ready[owner]=1, then IDLE; rsp_ready of non-owner ignored.
- REQ-011 Latency: handshake at edge N -> rsp_valid high in cycle N+3.
- REQ-012 req_ready SHALL be 0 in all states except IDLE; no request is lost or duplicated.

Reset
- REQ-013 While rst_a_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, we_a=0, all addr_a/din_a=0, FSM=IDLE, last_grant=1.
- REQ-014 Reset mid-transaction SHALL drop it with no response; the first request after release is serviced normally.

Configuration
- REQ-015 Macro SRAM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a conflict, and last_grant is unused. Undefined: round-robin per REQ-006.

Structure
- REQ-016 Package sram_arb_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, ANA_WIDTH, FULL_SCALE and THRESH defaults, and the FSM state enum.
- REQ-017 Sub-module sram_arb_rr SHALL hold the 2-way grant logic and last_grant register.

Verification
- REQ-018 Req0 write addr=2 data=0xA5 -> in CMD cycle: we_a=255; addr_a={0,0,255,0} for bits 3..0; din_a bits 7,5,2,0=255, others 0; rsp_valid[0] at N+3.
- REQ-019 Req1 read addr=2 -> rsp_valid[1] at N+3, rsp_rdata=0xA5, we_a=0 throughout.
- REQ-020 Req0 write addr=2 data=0x3C -> rsp_rdata=0xA5 (read-first); a following read of addr=2 returns 0x3C.
- REQ-021 Both req_valid held for 4 transactions after reset -> grants 0,1,0,1; with SRAM_ARB_FIXED_PRIO_EN -> 0,0,0,0.
- REQ-022 rsp_ready low for 5 cycles in RSP -> rsp_valid and rsp_rdata stable, req_ready=0; dout_a bit at 127 decodes to 0, at 128 decodes to 1.
- REQ-023 rst_a_n pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid; next request after release completes normally.
